// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that shares one cache_controller port between two
// requesters. It runs one transaction at a time (issue, wait, respond),
// aborts a transaction on timeout, and keeps saturating hit/miss counters.
module cache_req_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          req0,
    input  logic          req1,
    input  logic          op0,
    input  logic          op1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          hit,
    output logic          err,
    output logic          c_valid,
    output logic          c_opcode,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_wdata,
    input  logic          c_ready,
    input  logic          c_hit_miss,
    input  logic [DW-1:0] c_rdata,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
);

    // The timer only has to count up to TIMEOUT-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          rr_ptr;      // 0: port 0 favoured on contention, 1: port 1
    logic          win_id;      // port that owns the current transaction
    logic          win_sel;
    logic          any_req;
    logic          timer_exp;
    logic [TW-1:0] timer;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign any_req   = req0 | req1;
    // A lone requester always wins; on contention the pointer decides.
    assign win_sel   = (req0 & req1) ? rr_ptr : req1;
    assign timer_exp = (timer == TW'(TIMEOUT - 1));

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (c_ready || timer_exp) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) state <= IDLE;
        else       state <= state_nxt;
    end

    // Pick the winner, latch its request fields and move the pointer to the loser.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            rr_ptr   <= 1'b0;
            win_id   <= 1'b0;
            c_opcode <= 1'b0;
            c_addr   <= '0;
            c_wdata  <= '0;
        end else if (state == IDLE && any_req) begin
            win_id   <= win_sel;
            rr_ptr   <= ~win_sel;
            c_opcode <= win_sel ? op1    : op0;
            c_addr   <= win_sel ? addr1  : addr0;
            c_wdata  <= win_sel ? wdata1 : wdata0;
        end
    end

    // WAIT-cycle timer: cleared while issuing, counts while no completion arrives.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b)                                      timer <= '0;
        else if (state == ISSUE)                        timer <= '0;
        else if (state == WAIT && !c_ready && !timer_exp) timer <= timer + TW'(1);
    end

    // Capture the cache result (or the timeout) and update statistics.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            rdata    <= '0;
            hit      <= 1'b0;
            err      <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == WAIT) begin
            if (c_ready) begin
                rdata <= c_rdata;
                hit   <= c_hit_miss;
                err   <= 1'b0;
                if (c_hit_miss) hit_cnt  <= sat_inc(hit_cnt);
                else            miss_cnt <= sat_inc(miss_cnt);
            end else if (timer_exp) begin
                // Aborted: rdata keeps its old value, nothing is counted.
                hit <= 1'b0;
                err <= 1'b1;
            end
        end
    end

    // Grant/issue and done strobes decoded from state and owner.
    always_comb begin
        c_valid = (state == ISSUE);
        gnt0    = c_valid & ~win_id;
        gnt1    = c_valid &  win_id;
        done0   = (state == RESP) & ~win_id;
        done1   = (state == RESP) &  win_id;
    end

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
Shares the single cache_controller port between two requesters (port 0, port 1) with round-robin arbitration. Sequences one cache transaction at a time: issue, wait for cache completion or timeout, return result. Keeps saturating hit/miss statistics. Sits between requester logic and cache_controller.

Parameters:
AW, 8, address width
DW, 8, data width
TIMEOUT, 16, max WAIT cycles before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  reset, asynchronous, active-high (1 = reset)
req0 / req1  in  1  request; held high with fields stable until gnt
op0 / op1  in  1  opcode, 0 = read, 1 = write
addr0 / addr1  in  AW  address
wdata0 / wdata1  in  DW  write data
gnt0 / gnt1  out  1  one-cycle grant pulse, fields latched
done0 / done1  out  1  one-cycle completion pulse
rdata  out  DW  read data of last completed transaction
hit  out  1  hit(1)/miss(0) of last completed transaction
err  out  1  last transaction timed out
c_valid  out  1  one-cycle issue strobe to cache
c_opcode  out  1  latched opcode
c_addr  out  AW  latched address
c_wdata  out  DW  latched write data
c_ready  in  1  cache completion strobe
c_hit_miss  in  1  cache hit flag, valid with c_ready
c_rdata  in  DW  cache read data, valid with c_ready
hit_cnt / miss_cnt  out  16  saturating counters

Behaviour:
- Reset (async, rst_b=1): state IDLE; all outputs 0; rr pointer favours port 0; latched fields 0; counters 0; timer 0.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if req0|req1 sampled high, select winner, latch op/addr/wdata and winner id, go ISSUE. Neither: stay.
- Arbitration: single requester always wins. Both: port favoured by rr pointer wins; pointer then favours loser. Pointer updates only on grant.
- ISSUE (exactly 1 cycle): gnt<winner>=1, c_valid=1, c_* = latched fields; timer cleared; -> WAIT. c_ready in ISSUE ignored.
- WAIT: c_valid=0. c_ready=1: capture c_hit_miss, c_rdata, err=0, -> RESP. Else timer+1; when timer reaches TIMEOUT-1 without c_ready: err=1, rdata unchanged, hit=0, -> RESP.
- RESP (1 cycle): done<winner>=1; rdata/hit/err registered, held until next RESP. Non-error: hit -> hit_cnt+1, miss -> miss_cnt+1, saturate at 0xFFFF. Errors not counted. -> IDLE.
- Latency: req high at edge k -> gnt/c_valid cycle k+1; c_ready earliest cycle k+2; done earliest cycle k+3. Back-to-back: next grant no sooner than 1 cycle after done (IDLE cycle).
- Requests arriving while busy stay pending (requester holds req); no queueing beyond req line. req dropped before gnt: withdrawn, no grant, pointer unchanged.
- gnt0/gnt1 and done0/done1 mutually exclusive, never simultaneous.
- Write: rdata updated with c_rdata as returned (cache defines value).
- Reset mid-transaction: immediate return to IDLE, no done pulse; a later c_ready in IDLE ignored.
- c_ready outside WAIT ignored.

Test Plan:
- Reset: rst_b=1 for 10 ns -> all outputs 0, counters 0; c_ready pulsed in IDLE -> no done.
- Single read port 0, addr=0x12, cache returns c_ready 2 cycles after c_valid, hit=1, c_rdata=0xA5 -> gnt0 at k+1, c_addr=0x12, c_opcode=0, done0 with rdata=0xA5, hit=1, hit_cnt=1.
- req0 and req1 both high continuously, 4 transactions -> grants 0,1,0,1; c_addr alternates addr0/addr1.
- Miss write port 1, op1=1, wdata1=0x3C, c_hit_miss=0 -> c_wdata=0x3C, done1, hit=0, miss_cnt=1.
- Timeout: no c_ready after c_valid -> done pulse exactly TIMEOUT cycles after WAIT entry (16), err=1, counters unchanged; next request succeeds with err=0.
- Reset asserted during WAIT, then c_ready -> no done, state IDLE; hit_cnt forced to 0xFFFF by 65535 hits -> stays 0xFFFF after next hit.
